laser_job_sched: RTL and testbench

- Job controller and arbiter that shares one LASER two-circle coverage core between NREQ requesters.
- Per job:
  - Grants one requester.
  - Buffers its 40 points at the requester's pace.
  - Resets the core and streams all 40 points in 40 back-to-back cycles, which the core's handshake-free input requires.
  - Waits for core DONE under a watchdog.
  - Returns C1/C2 with the requester id.
- Sits between the requester fabric and the LASER core.

---
 rtl/laser_job_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_laser_job_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_job_sched.sv
// Job controller and round-robin arbiter that shares one LASER two-circle core between NREQ requesters.
// Each job buffers NPTS points, streams them into a freshly reset core, and returns C1/C2 under a watchdog.
module laser_job_sched #(
   parameter int NPTS = 40,
   parameter int NREQ = 2,
   parameter int TOUT = 4000,
   parameter int TW   = 12,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   input  logic            pt_valid,
   input  logic [3:0]      pt_x,
   input  logic [3:0]      pt_y,
   output logic            pt_ready,
   output logic            core_rst,
   output logic [3:0]      core_x,
   output logic [3:0]      core_y,
   input  logic            core_done,
   input  logic [3:0]      core_c1x,
   input  logic [3:0]      core_c1y,
   input  logic [3:0]      core_c2x,
   input  logic [3:0]      core_c2y,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [IDW-1:0]  res_id,
   output logic            res_err,
   output logic [3:0]      res_c1x,
   output logic [3:0]      res_c1y,
   output logic [3:0]      res_c2x,
   output logic [3:0]      res_c2y,
   output logic            busy
);

   typedef enum logic [2:0] {IDLE, FILL, LOAD, RUN, RESP} state_t;

   localparam logic [5:0]    LAST_PT = 6'(NPTS - 1);
   localparam logic [TW-1:0] WD_TOP  = TW'(TOUT - 1);

   state_t          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            pt_ready_q, pt_ready_d;
   logic            core_rst_q, core_rst_d;
   logic [3:0]      core_x_q, core_x_d, core_y_q, core_y_d;
   logic            res_valid_q, res_valid_d;
   logic            res_err_q, res_err_d;
   logic [IDW-1:0]  res_id_q, res_id_d;
   logic [15:0]     res_c_q, res_c_d;
   logic [IDW-1:0]  rr_q, rr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [TW-1:0]   wd_q, wd_d;
   logic [7:0]      pt_buf_q [NPTS];
   logic            wr_en_s;
   logic            found_s;
   logic [IDW-1:0]  winner_s;

   // Round-robin search from rr upward with wrap.
   always_comb begin
      int j;
      found_s  = 1'b0;
      winner_s = {IDW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         j = int'(rr_q) + i;
         if (j >= NREQ) begin
            j = j - NREQ;
         end else begin
            j = j;
         end
         if (!found_s && req[IDW'(j)]) begin
            found_s  = 1'b1;
            winner_s = IDW'(j);
         end else begin
            found_s  = found_s;
         end
      end
   end

   // Job sequencing: next state and next values of every registered output.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      pt_ready_d  = pt_ready_q;
      core_x_d    = 4'd0;
      core_y_d    = 4'd0;
      res_valid_d = res_valid_q;
      res_err_d   = res_err_q;
      res_id_d    = res_id_q;
      res_c_d     = res_c_q;
      rr_d        = rr_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      wd_d        = wd_q;
      wr_en_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if (found_s) begin
               state_d         = FILL;
               gnt_d           = {NREQ{1'b0}};
               gnt_d[winner_s] = 1'b1;
               pt_ready_d      = 1'b1;
               id_d            = winner_s;
               rr_d            = (winner_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : winner_s + IDW'(1);
               cnt_d           = 6'd0;
            end else begin
               state_d = IDLE;
            end
         end
         FILL: begin
            if (pt_valid && pt_ready_q) begin
               wr_en_s = 1'b1;
               if (cnt_q == LAST_PT) begin
                  state_d    = LOAD;
                  gnt_d      = {NREQ{1'b0}};
                  pt_ready_d = 1'b0;
                  cnt_d      = 6'd0;
                  core_x_d   = pt_buf_q[6'd0][3:0];
                  core_y_d   = pt_buf_q[6'd0][7:4];
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         LOAD: begin
            // core_x/core_y run one index ahead of cnt so point k is present during LOAD cycle k.
            if (cnt_q == LAST_PT) begin
               state_d = RUN;
               cnt_d   = 6'd0;
               wd_d    = {TW{1'b0}};
            end else begin
               cnt_d    = cnt_q + 6'd1;
               core_x_d = pt_buf_q[cnt_q + 6'd1][3:0];
               core_y_d = pt_buf_q[cnt_q + 6'd1][7:4];
            end
         end
         RUN: begin
            if (core_done) begin
               state_d     = RESP;
               res_valid_d = 1'b1;
               res_err_d   = 1'b0;
               res_id_d    = id_q;
               res_c_d     = {core_c1x, core_c1y, core_c2x, core_c2y};
            end else if (wd_q == WD_TOP) begin
               state_d     = RESP;
               res_valid_d = 1'b1;
               res_err_d   = 1'b1;
               res_id_d    = id_q;
               res_c_d     = 16'd0;
            end else begin
               wd_d = wd_q + TW'(1);
            end
         end
         RESP: begin
            if (res_ready) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = {NREQ{1'b0}};
            pt_ready_d  = 1'b0;
            res_valid_d = 1'b0;
         end
      endcase
      // Core is held in reset everywhere except LOAD and RUN, so every job starts from a clean core.
      core_rst_d = ((state_d == LOAD) || (state_d == RUN)) ? 1'b0 : 1'b1;
   end

   // Control and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         gnt_q       <= {NREQ{1'b0}};
         pt_ready_q  <= 1'b0;
         core_rst_q  <= 1'b1;
         core_x_q    <= 4'd0;
         core_y_q    <= 4'd0;
         res_valid_q <= 1'b0;
         res_err_q   <= 1'b0;
         res_id_q    <= {IDW{1'b0}};
         res_c_q     <= 16'd0;
         rr_q        <= {IDW{1'b0}};
         id_q        <= {IDW{1'b0}};
         cnt_q       <= 6'd0;
         wd_q        <= {TW{1'b0}};
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         pt_ready_q  <= pt_ready_d;
         core_rst_q  <= core_rst_d;
         core_x_q    <= core_x_d;
         core_y_q    <= core_y_d;
         res_valid_q <= res_valid_d;
         res_err_q   <= res_err_d;
         res_id_q    <= res_id_d;
         res_c_q     <= res_c_d;
         rr_q        <= rr_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         wd_q        <= wd_d;
      end
   end

   // Point buffer is pure datapath; every entry is rewritten before it is read.
   always_ff @(posedge CLK) begin
      if (wr_en_s) begin
         pt_buf_q[cnt_q] <= {pt_y, pt_x};
      end
   end

   assign gnt       = gnt_q;
   assign pt_ready  = pt_ready_q;
   assign core_rst  = core_rst_q;
   assign core_x    = core_x_q;
   assign core_y    = core_y_q;
   assign res_valid = res_valid_q;
   assign res_err   = res_err_q;
   assign res_id    = res_id_q;
   assign res_c1x   = res_c_q[15:12];
   assign res_c1y   = res_c_q[11:8];
   assign res_c2x   = res_c_q[7:4];
   assign res_c2y   = res_c_q[3:0];
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_laser_job_sched.sv
// Directed bench for laser_job_sched: drives requesters and a modelled core, checks grants, streaming and results.
module tb_laser_job_sched;
   localparam int NPTS = 40;
   localparam int TOUT = 4000;

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] req, gnt;
   logic       pt_valid, pt_ready;
   logic [3:0] pt_x, pt_y;
   logic       core_rst, core_done;
   logic [3:0] core_x, core_y, core_c1x, core_c1y, core_c2x, core_c2y;
   logic       res_valid, res_ready, res_err, busy;
   logic [0:0] res_id;
   logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0] g_gnt;
   int         g_acc, g_gnt_bad, g_extra, g_rst_bad, g_ticks, g_hold_bad;
   logic [7:0] g_seq [NPTS];

   laser_job_sched dut (
      .CLK(CLK), .RST(RST), .req(req), .gnt(gnt),
      .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .pt_ready(pt_ready),
      .core_rst(core_rst), .core_x(core_x), .core_y(core_y), .core_done(core_done),
      .core_c1x(core_c1x), .core_c1y(core_c1y), .core_c2x(core_c2x), .core_c2y(core_c2y),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_err(res_err),
      .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      tick();
   endtask

   task automatic do_grant(input logic [1:0] reqv, input bit keep);
      req = reqv;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (gnt != 2'b00) break;
      end
      g_gnt = gnt;
      if (!keep) req = 2'b00;
   endtask

   // Streams points (x = p%10, y = p/10); mode 1 inserts random valid gaps.
   task automatic do_fill(input int mode, input int done_at, input int abort_at);
      int p = 0;
      int guard = 0;
      g_acc = 0;
      g_gnt_bad = 0;
      while (p < NPTS && guard < 400) begin
         if (p == abort_at) return;
         pt_valid  = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
         pt_x      = pt_valid ? 4'(p % 10) : 4'hF;
         pt_y      = pt_valid ? 4'(p / 10) : 4'hF;
         core_done = (guard == done_at);
         if (gnt !== g_gnt) g_gnt_bad++;
         if (pt_valid && pt_ready) begin
            p++;
            g_acc++;
         end
         tick();
         guard++;
      end
      core_done = 1'b0;
      pt_valid  = 1'b1;
   endtask

   task automatic do_load();
      g_extra = 0;
      g_rst_bad = 0;
      for (int k = 0; k < NPTS; k++) begin
         g_seq[k] = {core_y, core_x};
         if (core_rst !== 1'b0) g_rst_bad++;
         if (pt_ready !== 1'b0 || gnt !== 2'b00) g_extra++;
         tick();
      end
      pt_valid = 1'b0;
   endtask

   task automatic do_run(input int done_at, input int abort_at, input logic [15:0] c);
      g_ticks = 0;
      for (int cyc = 0; cyc < TOUT + 20; cyc++) begin
         if (res_valid === 1'b1) break;
         if (cyc == abort_at) return;
         core_done = (cyc == done_at);
         {core_c1x, core_c1y, core_c2x, core_c2y} = c;
         tick();
         g_ticks++;
      end
      core_done = 1'b0;
   endtask

   task automatic do_resp(input int hold, input logic [1:0] reqv);
      logic [17:0] snap;
      snap = {res_id, res_err, res_c1x, res_c1y, res_c2x, res_c2y};
      g_hold_bad = 0;
      req = reqv;
      for (int i = 0; i < hold; i++) begin
         if ({res_id, res_err, res_c1x, res_c1y, res_c2x, res_c2y} !== snap ||
             res_valid !== 1'b1 || gnt !== 2'b00) g_hold_bad++;
         tick();
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      n_cmp++;
      if ({gnt, pt_ready, core_rst, core_x, core_y, res_valid, res_err, res_id,
           res_c1x, res_c1y, res_c2x, res_c2y, busy} !== 32'h1000_0000) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 10000000", {gnt, pt_ready, core_rst, core_x, core_y,
                  res_valid, res_err, res_id, res_c1x, res_c1y, res_c2x, res_c2y, busy});
      end
      RST = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({gnt, pt_ready, core_rst, busy} !== 5'b00010) begin
         n_bad++;
         $display("FAIL idle_after_reset: got %b want 00010", {gnt, pt_ready, core_rst, busy});
      end
   endtask

   task automatic test_single();
      int errs = 0;
      do_grant(2'b01, 1'b0);
      n_cmp++;
      if (g_gnt !== 2'b01) begin n_bad++; $display("FAIL single_gnt: got %b want 01", g_gnt); end
      do_fill(0, -1, -1);
      n_cmp++;
      if (g_acc !== NPTS || g_gnt_bad !== 0) begin
         n_bad++;
         $display("FAIL single_fill: accepts %0d gnt_glitches %0d want 40/0", g_acc, g_gnt_bad);
      end
      do_load();
      for (int k = 0; k < NPTS; k++) if (g_seq[k] !== 8'((k / 10) * 16 + (k % 10))) errs++;
      n_cmp++;
      if (errs != 0 || g_rst_bad != 0 || g_extra != 0) begin
         n_bad++;
         $display("FAIL single_stream: bad_pts %0d rst_bad %0d extra %0d want 0/0/0", errs, g_rst_bad, g_extra);
      end
      n_cmp++;
      if ({core_rst, core_x, core_y} !== 9'd0) begin
         n_bad++;
         $display("FAIL run_core_idle: got %h want 000", {core_rst, core_x, core_y});
      end
      do_run(5, -1, {4'd3, 4'd4, 4'd11, 4'd9});
      n_cmp++;
      if (g_ticks !== 6 || res_valid !== 1'b1 || core_rst !== 1'b1) begin
         n_bad++;
         $display("FAIL single_done: ticks %0d valid %b core_rst %b want 6/1/1", g_ticks, res_valid, core_rst);
      end
      n_cmp++;
      if ({res_id, res_err, res_c1x, res_c1y, res_c2x, res_c2y} !== {1'b0, 1'b0, 16'h34B9}) begin
         n_bad++;
         $display("FAIL single_result: got %h want 034b9", {res_id, res_err, res_c1x, res_c1y, res_c2x, res_c2y});
      end
      do_resp(0, 2'b00);
      n_cmp++;
      if ({res_valid, busy, core_rst} !== 3'b001) begin
         n_bad++;
         $display("FAIL single_accept: got %b want 001", {res_valid, busy, core_rst});
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int j = 0; j < 3; j++) begin
         do_grant(2'b11, 1'b1);
         n_cmp++;
         if (g_gnt !== ((j % 2 == 0) ? 2'b01 : 2'b10)) begin
            n_bad++;
            $display("FAIL rr_gnt%0d: got %b want %b", j, g_gnt, (j % 2 == 0) ? 2'b01 : 2'b10);
         end
         do_fill(0, -1, -1);
         do_load();
         do_run(2, -1, 16'h1111);
         n_cmp++;
         if (res_valid !== 1'b1 || res_id !== 1'((j % 2))) begin
            n_bad++;
            $display("FAIL rr_id%0d: valid %b id %0d want 1/%0d", j, res_valid, res_id, j % 2);
         end
         do_resp(0, (j == 2) ? 2'b00 : 2'b11);
      end
   endtask

   task automatic test_backpressure();
      int errs = 0;
      do_grant(2'b01, 1'b0);
      do_fill(1, -1, -1);
      do_load();
      for (int k = 0; k < NPTS; k++) if (g_seq[k] !== 8'((k / 10) * 16 + (k % 10))) errs++;
      n_cmp++;
      if (errs != 0 || g_acc != NPTS || g_extra != 0) begin
         n_bad++;
         $display("FAIL gap_stream: bad_pts %0d accepts %0d extra %0d want 0/40/0", errs, g_acc, g_extra);
      end
      do_run(7, -1, 16'h1234);
      do_resp(20, 2'b10);
      n_cmp++;
      if (g_hold_bad !== 0) begin
         n_bad++;
         $display("FAIL resp_hold: %0d unstable cycles want 0", g_hold_bad);
      end
      n_cmp++;
      if (gnt !== 2'b00) begin n_bad++; $display("FAIL early_gnt: got %b want 00", gnt); end
      tick();
      req = 2'b00;
      n_cmp++;
      if (gnt !== 2'b10) begin n_bad++; $display("FAIL post_accept_gnt: got %b want 10", gnt); end
      apply_reset();
   endtask

   task automatic test_watchdog();
      do_grant(2'b01, 1'b0);
      do_fill(0, -1, -1);
      do_load();
      do_run(-1, -1, 16'hFFFF);
      n_cmp++;
      if (g_ticks !== TOUT || res_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL wd_latency: ticks %0d valid %b want 4000/1", g_ticks, res_valid);
      end
      n_cmp++;
      if ({res_err, res_c1x, res_c1y, res_c2x, res_c2y} !== {1'b1, 16'h0000}) begin
         n_bad++;
         $display("FAIL wd_result: got %h want 10000", {res_err, res_c1x, res_c1y, res_c2x, res_c2y});
      end
      do_resp(0, 2'b00);
      do_grant(2'b01, 1'b0);
      do_fill(0, -1, -1);
      do_load();
      do_run(3, -1, 16'h5A3C);
      n_cmp++;
      if (g_ticks !== 4 || {res_err, res_c1x, res_c1y, res_c2x, res_c2y} !== {1'b0, 16'h5A3C}) begin
         n_bad++;
         $display("FAIL wd_recover: ticks %0d got %h want 4/05a3c", g_ticks,
                  {res_err, res_c1x, res_c1y, res_c2x, res_c2y});
      end
      do_resp(0, 2'b00);
   endtask

   task automatic test_edge_events();
      int errs = 0;
      do_grant(2'b01, 1'b0);
      do_fill(0, 10, -1);
      do_load();
      for (int k = 0; k < NPTS; k++) if (g_seq[k] !== 8'((k / 10) * 16 + (k % 10))) errs++;
      n_cmp++;
      if (errs != 0 || res_valid !== 1'b0 || core_rst !== 1'b0) begin
         n_bad++;
         $display("FAIL fill_done_ignored: bad_pts %0d valid %b core_rst %b want 0/0/0", errs, res_valid, core_rst);
      end
      do_run(TOUT - 1, -1, 16'h1234);
      n_cmp++;
      if (g_ticks !== TOUT || {res_err, res_c1x, res_c2y} !== 9'h014) begin
         n_bad++;
         $display("FAIL done_at_timeout: ticks %0d got %h want 4000/014", g_ticks, {res_err, res_c1x, res_c2y});
      end
      do_resp(0, 2'b00);
   endtask

   task automatic test_reset_mid();
      int errs = 0;
      do_grant(2'b01, 1'b0);
      do_fill(0, -1, 17);
      RST = 1'b1;
      #1;
      n_cmp++;
      if ({gnt, pt_ready, core_rst, core_x, core_y, res_valid, res_err, res_id,
           res_c1x, res_c1y, res_c2x, res_c2y, busy} !== 32'h1000_0000) begin
         n_bad++;
         $display("FAIL reset_in_fill: got %h want 10000000", {gnt, pt_ready, core_rst, core_x, core_y,
                  res_valid, res_err, res_id, res_c1x, res_c1y, res_c2x, res_c2y, busy});
      end
      pt_valid = 1'b0;
      tick();
      RST = 1'b0;
      tick();
      do_grant(2'b01, 1'b0);
      do_fill(0, -1, -1);
      do_load();
      do_run(-1, 10, 16'h9999);
      RST = 1'b1;
      #1;
      n_cmp++;
      if ({gnt, pt_ready, core_rst, core_x, core_y, res_valid, res_err, res_id,
           res_c1x, res_c1y, res_c2x, res_c2y, busy} !== 32'h1000_0000) begin
         n_bad++;
         $display("FAIL reset_in_run: got %h want 10000000", {gnt, pt_ready, core_rst, core_x, core_y,
                  res_valid, res_err, res_id, res_c1x, res_c1y, res_c2x, res_c2y, busy});
      end
      core_done = 1'b0;
      tick();
      RST = 1'b0;
      tick();
      do_grant(2'b01, 1'b0);
      do_fill(0, -1, -1);
      do_load();
      for (int k = 0; k < NPTS; k++) if (g_seq[k] !== 8'((k / 10) * 16 + (k % 10))) errs++;
      do_run(4, -1, 16'h7E21);
      n_cmp++;
      if (errs != 0 || g_ticks !== 5 || {res_id, res_err, res_c1x, res_c1y, res_c2x, res_c2y} !== {2'b00, 16'h7E21}) begin
         n_bad++;
         $display("FAIL after_reset_job: bad_pts %0d ticks %0d got %h want 0/5/07e21", errs, g_ticks,
                  {res_id, res_err, res_c1x, res_c1y, res_c2x, res_c2y});
      end
      do_resp(0, 2'b00);
   endtask

   initial begin
      RST = 1'b1;
      req = 2'b00;
      pt_valid = 1'b0;
      pt_x = 4'd0;
      pt_y = 4'd0;
      core_done = 1'b0;
      {core_c1x, core_c1y, core_c2x, core_c2y} = 16'd0;
      res_ready = 1'b0;
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_watchdog();
      test_edge_events();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
